data_mem_responder: RTL

Multi-cycle data-memory responder that serves the pipeline's memory stage over a valid/ready request and one-shot response handshake. It holds a word-organised RAM with little-endian byte lanes and performs word, halfword and byte loads and stores. Loads are sign- or zero-extended, and misaligned accesses are rejected. It replaces the single-cycle data memory, and the memory stage stalls on `ReqReady` until `RespValid` returns.

---
 rtl/data_mem_responder_if.sv | 33 +++
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline memory stage and the data-memory responder.
//   req_valid/req_ready      : request handshake (accepted when both high)
//   req_write                : 1 = store, 0 = load
//   req_byte/req_half        : access size (byte wins if both set; neither = word)
//   req_unsigned             : zero-extend load data instead of sign-extending
//   req_address              : byte address
//   req_write_data           : store data, taken from the low-order lanes
//   resp_valid               : one-cycle response pulse
//   resp_read_data           : extended load data, 0 for stores and errors
//   resp_error               : misaligned request, qualified by resp_valid
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_half;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_byte, req_half, req_unsigned, req_address, req_write_data,
    input  req_ready, resp_valid, resp_read_data, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_half, req_unsigned, req_address, req_write_data,
    output req_ready, resp_valid, resp_read_data, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the pipeline memory stage.
// Word-organised RAM with little-endian byte lanes; word/half/byte loads and stores,
// sign/zero-extended loads, misaligned requests answered with an error and no RAM access.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset (RAM contents are not reset)
//   bus_io : slave side of data_mem_responder_if (request handshake + one-shot response)
module data_mem_responder #(
  parameter int unsigned DEPTH_BITS = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  data_mem_responder_if.slave    bus_io
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        half_q, half_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0]           mem_q [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] word_idx;
  logic [31:0]           word_rd;
  logic [31:0]           word_shifted;
  logic [31:0]           load_data;
  logic [3:0]            byte_en;
  logic [31:0]           write_lanes;
  logic                  mem_we;
  logic                  handshake;
  logic                  misaligned;

  // Upper address bits only alias; fold them so they are visibly consumed.
  logic unused_addr;
  assign unused_addr = ^addr_q[31:DEPTH_BITS+2];

  assign handshake = bus_io.req_valid && (state_q == StIdle);

  // Byte accesses are never misaligned; byte takes priority over half.
  assign misaligned = !bus_io.req_byte &&
                      ((bus_io.req_half && bus_io.req_address[0]) ||
                       (!bus_io.req_half && (bus_io.req_address[1:0] != 2'b00)));

  assign word_idx = addr_q[DEPTH_BITS+1:2];
  assign word_rd  = mem_q[word_idx];

  // Right-justify the addressed lane(s), then extend.
  assign word_shifted = word_rd >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = word_rd;
    if (byte_q) begin
      load_data = unsigned_q ? {24'h0, word_shifted[7:0]}
                             : {{24{word_shifted[7]}}, word_shifted[7:0]};
    end else if (half_q) begin
      load_data = unsigned_q ? {16'h0, word_shifted[15:0]}
                             : {{16{word_shifted[15]}}, word_shifted[15:0]};
    end
  end

  // Replicate store data across lanes so the byte enables alone pick the target lane.
  always_comb begin
    byte_en     = 4'b1111;
    write_lanes = wdata_q;
    if (byte_q) begin
      byte_en     = 4'b0001 << addr_q[1:0];
      write_lanes = {4{wdata_q[7:0]}};
    end else if (half_q) begin
      byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
      write_lanes = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    byte_d     = byte_q;
    half_d     = half_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          write_d    = bus_io.req_write;
          byte_d     = bus_io.req_byte;
          half_d     = bus_io.req_half;
          unsigned_d = bus_io.req_unsigned;
          addr_d     = bus_io.req_address;
          wdata_d    = bus_io.req_write_data;
          rdata_d    = 32'h0;
          if (misaligned) begin
            error_d = 1'b1;
            state_d = StResp;
          end else begin
            error_d = 1'b0;
            cnt_d   = 4'(LATENCY - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          // Array access happens on the edge that leaves WAIT.
          mem_we  = write_q;
          rdata_d = write_q ? 32'h0 : load_data;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        rdata_d = 32'h0;
        error_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      unsigned_q <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      byte_q     <= byte_d;
      half_q     <= half_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped with the request.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= write_lanes[8*i +: 8];
        end
      end
    end
  end

  assign bus_io.req_ready      = (state_q == StIdle);
  assign bus_io.resp_valid     = (state_q == StResp);
  assign bus_io.resp_read_data = rdata_q;
  assign bus_io.resp_error     = error_q;

endmodule
